// File: rtl/alut_age_checker_pkg.sv
// rtl/alut_age_checker_pkg.sv - shared constants, entry field map and FSM encodings for the ALUT age checker
package alut_age_checker_pkg;

  localparam int ALUT_DEPTH = 256;
  localparam int ALUT_TS_W  = 32;
  localparam int ENTRY_W    = 83;

  // ALUT entry layout: {valid, time[31:0], port[1:0], addr[47:0]}
  localparam int VALID_BIT = 82;
  localparam int TIME_HI   = 81;
  localparam int TIME_LO   = 50;
  localparam int PORT_HI   = 49;
  localparam int PORT_LO   = 48;
  localparam int ADDR_HI   = 47;
  localparam int ADDR_LO   = 0;

  localparam logic [1:0] CMD_SWEEP = 2'b10;

  typedef enum logic [1:0] {
    A_IDLE,
    A_CALC,
    A_RESP
  } resp_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CHK,
    S_WR
  } sweep_state_t;

  // Same entry with only the valid bit dropped
  function automatic logic [ENTRY_W-1:0] invalidate_entry(input logic [ENTRY_W-1:0] e);
    logic [ENTRY_W-1:0] r;
    r            = e;
    r[VALID_BIT] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/alut_age_checker_if.sv
// rtl/alut_age_checker_if.sv - age-check handshake and shared ALUT memory port
interface alut_age_checker_if;
  import alut_age_checker_pkg::*;

  logic                 check_age;
  logic [ALUT_TS_W-1:0] last_accessed;
  logic                 age_confirmed;
  logic                 age_ok;
  logic                 add_check_active;
  logic [ENTRY_W-1:0]   mem_read_data_age;
  logic [7:0]           mem_addr_age;
  logic                 mem_write_age;
  logic [ENTRY_W-1:0]   mem_write_data_age;

  // Address checker and ALUT memory side
  modport master (
    output check_age, last_accessed, add_check_active, mem_read_data_age,
    input  age_confirmed, age_ok, mem_addr_age, mem_write_age, mem_write_data_age
  );

  // Age checker side
  modport slave (
    input  check_age, last_accessed, add_check_active, mem_read_data_age,
    output age_confirmed, age_ok, mem_addr_age, mem_write_age, mem_write_data_age
  );

endinterface

// File: rtl/alut_age_compare.sv
// rtl/alut_age_compare.sv - modular timestamp delta and in-date compare
module alut_age_compare #(
  parameter int W = 32
) (
  input  logic [W-1:0] now,
  input  logic [W-1:0] stamp,
  input  logic [W-1:0] limit,
  output logic         in_date
);

  logic [W-1:0] delta;

  // Unsigned wrap-around subtraction makes timer rollover harmless
  always_comb begin
    delta   = now - stamp;
    in_date = (delta <= limit);
  end

endmodule

// File: rtl/alut_age_checker.sv
// rtl/alut_age_checker.sv - age-check responder plus background stale sweep (optional ALUT_AGE_STATS_EN adds inval_count)
module alut_age_checker
  import alut_age_checker_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int TS_W  = 32
) (
  input  logic                pclk,
  input  logic                n_p_reset,
  input  logic [1:0]          command,
  input  logic [TS_W-1:0]     curr_time,
  input  logic [TS_W-1:0]     max_age,
  alut_age_checker_if.slave   bus,
  output logic                age_check_active,
  output logic [47:0]         lst_inv_addr_age,
  output logic [1:0]          lst_inv_port_age
`ifdef ALUT_AGE_STATS_EN
  ,
  output logic [8:0]          inval_count
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

  // ---------------- responder ----------------
  resp_state_t       resp_q, resp_d;
  logic [TS_W-1:0]   last_q, last_d;
  logic              in_date_q, in_date_d;
  logic              resp_in_date;

  alut_age_compare #(.W(TS_W)) u_resp_cmp (
    .now     (curr_time),
    .stamp   (last_q),
    .limit   (max_age),
    .in_date (resp_in_date)
  );

  // Responder state, sampled timestamp and registered verdict
  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      resp_q    <= A_IDLE;
      last_q    <= '0;
      in_date_q <= 1'b0;
    end else begin
      resp_q    <= resp_d;
      last_q    <= last_d;
      in_date_q <= in_date_d;
    end
  end

  // Responder next state; requests arriving while busy are dropped on purpose
  always_comb begin
    resp_d            = resp_q;
    last_d            = last_q;
    in_date_d         = in_date_q;
    bus.age_confirmed = 1'b0;
    bus.age_ok        = 1'b0;
    case (resp_q)
      A_IDLE: begin
        if (bus.check_age) begin
          last_d = bus.last_accessed;
          resp_d = A_CALC;
        end
      end
      A_CALC: begin
        in_date_d = resp_in_date;
        resp_d    = A_RESP;
      end
      A_RESP: begin
        bus.age_confirmed = 1'b1;
        bus.age_ok        = in_date_q;
        resp_d            = A_IDLE;
      end
      default: resp_d = A_IDLE;
    endcase
  end

  // ---------------- sweep ----------------
  sweep_state_t        sweep_q, sweep_d;
  logic [7:0]          idx_q, idx_d;
  logic [ENTRY_W-1:0]  rd_q, rd_d;
  logic [47:0]         lst_addr_q, lst_addr_d;
  logic [1:0]          lst_port_q, lst_port_d;
  logic                sweep_in_date;
  logic                stale;
  logic                busy;

`ifdef ALUT_AGE_STATS_EN
  localparam logic [8:0] CNT_MAX = 9'(DEPTH);
  logic [8:0] cnt_q, cnt_d;
`endif

  alut_age_compare #(.W(TS_W)) u_sweep_cmp (
    .now     (curr_time),
    .stamp   (rd_q[TIME_HI:TIME_LO]),
    .limit   (max_age),
    .in_date (sweep_in_date)
  );

  assign busy  = bus.add_check_active;
  assign stale = rd_q[VALID_BIT] & ~sweep_in_date;

  // Sweep state, index, captured entry and last-invalidated record
  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      sweep_q    <= S_IDLE;
      idx_q      <= '0;
      rd_q       <= '0;
      lst_addr_q <= '0;
      lst_port_q <= '0;
`ifdef ALUT_AGE_STATS_EN
      cnt_q      <= '0;
`endif
    end else begin
      sweep_q    <= sweep_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      lst_addr_q <= lst_addr_d;
      lst_port_q <= lst_port_d;
`ifdef ALUT_AGE_STATS_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Sweep next state; the address checker owns memory whenever busy is high
  always_comb begin
    sweep_d                = sweep_q;
    idx_d                  = idx_q;
    rd_d                   = rd_q;
    lst_addr_d             = lst_addr_q;
    lst_port_d             = lst_port_q;
    bus.mem_write_age      = 1'b0;
    bus.mem_write_data_age = '0;
`ifdef ALUT_AGE_STATS_EN
    cnt_d                  = cnt_q;
`endif
    case (sweep_q)
      S_IDLE: begin
        if (!busy && command == CMD_SWEEP) begin
          idx_d   = '0;
          sweep_d = S_RD;
`ifdef ALUT_AGE_STATS_EN
          cnt_d   = '0;
`endif
        end
      end
      S_RD: begin
        if (!busy) sweep_d = S_WAIT;
      end
      S_WAIT: begin
        if (busy) begin
          sweep_d = S_RD;
        end else begin
          rd_d    = bus.mem_read_data_age;
          sweep_d = S_CHK;
        end
      end
      S_CHK: begin
        if (busy) begin
          // captured data may have been disturbed; read the same index again
          sweep_d = S_RD;
        end else if (stale) begin
          sweep_d = S_WR;
        end else if (idx_q == LAST_IDX) begin
          sweep_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          sweep_d = S_RD;
        end
      end
      S_WR: begin
        if (!busy) begin
          bus.mem_write_age      = 1'b1;
          bus.mem_write_data_age = invalidate_entry(rd_q);
          lst_addr_d             = rd_q[ADDR_HI:ADDR_LO];
          lst_port_d             = rd_q[PORT_HI:PORT_LO];
`ifdef ALUT_AGE_STATS_EN
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 9'd1;
`endif
          if (idx_q == LAST_IDX) begin
            sweep_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            sweep_d = S_RD;
          end
        end
      end
      default: sweep_d = S_IDLE;
    endcase
  end

  assign bus.mem_addr_age = idx_q;
  assign age_check_active = (sweep_q != S_IDLE);
  assign lst_inv_addr_age = lst_addr_q;
  assign lst_inv_port_age = lst_port_q;
`ifdef ALUT_AGE_STATS_EN
  assign inval_count      = cnt_q;
`endif

endmodule
